// File: rtl/stepper_pkg.sv
// Shared types for the stepper command master: FSM states, the buffered command
// record and the command buffer depth.
package stepper_pkg;

    localparam int STEPPER_PULSE_NUM_BITS   = 8;
    localparam int STEPPER_PULSE_WIDTH_BITS = 8;
    localparam int STEPPER_FIFO_DEPTH       = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT_DONE,
        RETIRE
    } stepper_master_state_t;

    typedef struct packed {
        logic signed [STEPPER_PULSE_NUM_BITS-1:0] pulse_num;
        logic [STEPPER_PULSE_WIDTH_BITS-1:0]      pulse_width;
    } stepper_cmd_t;

endpackage

// File: rtl/stepper_ctrl_if.sv
// Master/slave link to one StepperCtrl axis driver; the slave holds done high
// while idle and starts a move when it sees trigger on a clk_en tick.
interface StepperCtrl_IF #(
    parameter int PULSE_NUM_BITS   = 8,
    parameter int PULSE_WIDTH_BITS = 8
);
    logic                               trigger;
    logic signed [PULSE_NUM_BITS-1:0]   pulse_num;
    logic [PULSE_WIDTH_BITS-1:0]        pulse_width;
    logic                               done;

    modport master (output trigger, output pulse_num, output pulse_width, input done);
    modport slave  (input trigger, input pulse_num, input pulse_width, output done);
endinterface

// File: rtl/stepper_cmd_fifo.sv
// Small show-ahead FIFO of stepper commands; full/empty are registered so the
// upstream ready never depends combinationally on this cycle's pop.
module stepper_cmd_fifo
    import stepper_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  stepper_cmd_t push_data_i,
    input  logic         pop_i,
    output stepper_cmd_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(STEPPER_FIFO_DEPTH);

    stepper_cmd_t     mem_q [STEPPER_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(STEPPER_FIFO_DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/stepper_ctrl_master.sv
// Command-side master for one StepperCtrl axis: buffers moves and issues them one
// at a time. Optional watchdog on WAIT_DONE enabled by STEPPER_MASTER_TIMEOUT_EN.
module stepper_ctrl_master
    import stepper_pkg::*;
#(
    parameter int PULSE_NUM_BITS   = STEPPER_PULSE_NUM_BITS,
    parameter int PULSE_WIDTH_BITS = STEPPER_PULSE_WIDTH_BITS,
    parameter int TIMEOUT_BITS     = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               clk_en_i,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic signed [PULSE_NUM_BITS-1:0]   cmd_pulse_num_i,
    input  logic [PULSE_WIDTH_BITS-1:0]        cmd_pulse_width_i,
    StepperCtrl_IF.master                      intf,
    output logic                               busy_o,
    output logic                               move_done_o,
    output logic                               err_o
);

    stepper_master_state_t               state_q;
    stepper_master_state_t               state_d;
    stepper_cmd_t                        push_cmd;
    stepper_cmd_t                        head;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                fifo_pop;
    logic signed [PULSE_NUM_BITS-1:0]    pulse_num_q;
    logic [PULSE_WIDTH_BITS-1:0]         pulse_width_q;
    logic                                busy_q;
    logic                                move_done_q;
    logic                                timeout_hit;

    assign push_cmd.pulse_num   = cmd_pulse_num_i;
    assign push_cmd.pulse_width = cmd_pulse_width_i;
    assign fifo_pop             = (state_q == IDLE) && !fifo_empty;

    stepper_cmd_fifo u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (cmd_valid_i),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef STEPPER_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [TIMEOUT_BITS-1:0] to_cnt_q;
    logic                    err_q;

    // The tick that would carry the counter to all-ones is the one that gives up.
    assign timeout_hit = (state_q == WAIT_DONE) && clk_en_i && !intf.done
                         && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == SETTLE) begin
                to_cnt_q <= '0;
            end else if (state_q == WAIT_DONE && clk_en_i) begin
                to_cnt_q <= to_cnt_q + TIMEOUT_BITS'(1);
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout_bits;

    assign unused_timeout_bits = (TIMEOUT_BITS > 0);
    assign timeout_hit         = 1'b0;
    assign err_o               = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = (head.pulse_num == '0) ? RETIRE : ISSUE;
            end
            ISSUE: begin
                if (clk_en_i) state_d = SETTLE;
            end
            // One extra tick so the slave's registered done has dropped.
            SETTLE: begin
                if (clk_en_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (clk_en_i && intf.done) begin
                    state_d = RETIRE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        intf.trigger     = (state_q == ISSUE);
        intf.pulse_num   = pulse_num_q;
        intf.pulse_width = pulse_width_q;
        move_done_o      = move_done_q;
        busy_o           = busy_q;
        cmd_ready_o      = !fifo_full;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pulse_num_q   <= '0;
            pulse_width_q <= '0;
            busy_q        <= 1'b0;
            move_done_q   <= 1'b0;
        end else begin
            if (fifo_pop) begin
                pulse_num_q   <= head.pulse_num;
                pulse_width_q <= head.pulse_width;
            end
            busy_q      <= (state_q != IDLE) || !fifo_empty;
            move_done_q <= (state_q == RETIRE);
        end
    end

endmodule

// File: tb/tb_stepper_ctrl_master.sv
// Bench for stepper_ctrl_master with a behavioural StepperCtrl slave and a
// command-queue scoreboard; the watchdog scenario builds with STEPPER_MASTER_TIMEOUT_EN.
module tb_stepper_ctrl_master;

    localparam int PN = 8;
    localparam int PW = 8;

    typedef struct {
        int num;
        int width;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic signed [PN-1:0] cmd_num = '0;
    logic [PW-1:0]     cmd_width = '0;
    logic              busy;
    logic              move_done;
    logic              err;

    StepperCtrl_IF #(.PULSE_NUM_BITS(PN), .PULSE_WIDTH_BITS(PW)) sif ();

    stepper_ctrl_master #(.PULSE_NUM_BITS(PN), .PULSE_WIDTH_BITS(PW), .TIMEOUT_BITS(16)) dut (
        .clk_i             (clk),
        .reset_i           (rst_n),
        .clk_en_i          (clk_en),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_pulse_num_i   (cmd_num),
        .cmd_pulse_width_i (cmd_width),
        .intf              (sif),
        .busy_o            (busy),
        .move_done_o       (move_done),
        .err_o             (err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input int obs, input int exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        #2 clk_en = ~clk_en;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave: |pulse_num| step pulses, each pulse_width ticks low then high.
    logic s_done, s_step, s_dir;
    int   s_rem, s_w, s_tick;
    assign sif.done = s_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            s_done <= 1'b1; s_step <= 1'b0; s_dir <= 1'b0;
            s_rem <= 0; s_w <= 1; s_tick <= 0;
        end else if (clk_en) begin
            if (s_done) begin
                if (sif.trigger) begin
                    s_rem  <= (int'(sif.pulse_num) < 0) ? -int'(sif.pulse_num) : int'(sif.pulse_num);
                    s_dir  <= (int'(sif.pulse_num) < 0);
                    s_w    <= (sif.pulse_width == '0) ? 1 : int'(sif.pulse_width);
                    s_tick <= 0;
                    s_step <= 1'b0;
                    s_done <= 1'b0;
                end
            end else if (s_rem == 0) begin
                s_done <= 1'b1;
            end else if (s_tick + 1 == s_w) begin
                s_tick <= 0;
                s_step <= ~s_step;
                if (s_step) s_rem <= s_rem - 1;
            end else begin
                s_tick <= s_tick + 1;
            end
        end
    end

    // Scoreboard: every accepted command retires once, in order, with the right activity.
    logic trig_prev, md_prev, step_prev;
    int   trig_ce, steps, got_trig, md_count;
    initial begin
        trig_ce = 0; steps = 0; got_trig = 0; md_count = 0;
        trig_prev = 0; md_prev = 0; step_prev = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            trig_prev = 0; md_prev = 0; step_prev = 0;
        end else begin
            if (sif.trigger && !trig_prev) begin
                if (exp_q.size() == 0) begin
                    check("trig_unexpected", 1, 0);
                end else begin
                    check("trig_num", int'(sif.pulse_num), exp_q[0].num);
                    check("trig_width", int'(sif.pulse_width), exp_q[0].width);
                end
                trig_ce = 0; steps = 0; got_trig = 1;
            end
            if (sif.trigger && clk_en) trig_ce++;
            if (!sif.trigger && trig_prev) check("trig_overlap", trig_ce, 1);
            if (s_step && !step_prev) steps++;
            if (move_done) begin
                check("md_single", int'(md_prev), 0);
                if (!md_prev) begin
                    if (exp_q.size() == 0) begin
                        check("md_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("md_trig", got_trig, int'(e.num != 0));
                        check("md_num_hold", int'(sif.pulse_num), e.num);
                        check("md_busy", int'(busy), 1);
                        if (e.num != 0) begin
                            check("md_steps", steps, (e.num < 0) ? -e.num : e.num);
                            check("md_dir", int'(s_dir), int'(e.num < 0));
                        end
                        md_count++;
                        $display("move retired: num=%0d width=%0d steps=%0d", e.num, e.width, steps);
                        got_trig = 0;
                    end
                end
            end
            trig_prev = sif.trigger; md_prev = move_done; step_prev = s_step;
        end
    end

    task automatic push(input int num, input int width);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_num   = num[PN-1:0];
        cmd_width = width[PW-1:0];
        @(posedge clk);
        exp_q.push_back('{num, width});
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 4000);
        check(tag, int'(busy || exp_q.size() != 0), 0);
    endtask

`ifdef STEPPER_MASTER_TIMEOUT_EN
    logic                 to_valid = 1'b0;
    logic                 to_ready, to_busy, to_md, to_err;
    logic signed [PN-1:0] to_num = '0;
    logic [PW-1:0]        to_width = '0;

    StepperCtrl_IF #(.PULSE_NUM_BITS(PN), .PULSE_WIDTH_BITS(PW)) sif_to ();
    assign sif_to.done = 1'b0;

    stepper_ctrl_master #(.PULSE_NUM_BITS(PN), .PULSE_WIDTH_BITS(PW), .TIMEOUT_BITS(4)) dut_to (
        .clk_i             (clk),
        .reset_i           (rst_n),
        .clk_en_i          (clk_en),
        .cmd_valid_i       (to_valid),
        .cmd_ready_o       (to_ready),
        .cmd_pulse_num_i   (to_num),
        .cmd_pulse_width_i (to_width),
        .intf              (sif_to),
        .busy_o            (to_busy),
        .move_done_o       (to_md),
        .err_o             (to_err)
    );
`endif

    initial begin
        int w, seen, md_base, n, t, cnum, cwid;

        // 1: reset values, then a quiet idle block
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_trigger", int'(sif.trigger), 0);
        check("rst_pulse_num", int'(sif.pulse_num), 0);
        check("rst_pulse_width", int'(sif.pulse_width), 0);
        check("rst_move_done", int'(move_done), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sif.trigger || busy) seen = 1;
        end
        check("idle_quiet", seen, 0);

        // 2: single negative move
        push(-4, 2);
        wait_idle("t2_idle");

        // 3: zero move retires without a trigger, move_done two cycles after the pop cycle
        push(0, 5);
        w = cyc;
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            @(negedge clk);
            if (move_done) seen = cyc;
        end
        check("t3_md_latency", seen - w, 2);
        wait_idle("t3_idle");

        // 4: three back-to-back commands fill the buffer
        md_base = md_count;
        push(-4, 2);
        push(2, 3);
        push(1, 1);
        @(negedge clk);
        check("t4_ready_full", int'(cmd_ready), 0);
        check("t4_busy", int'(busy), 1);
        wait_idle("t4_idle");
        check("t4_md_count", md_count - md_base, 3);
        check("t4_busy_after", int'(busy), 0);

        // 5: reset in WAIT_DONE of the 2/3 move with 1/1 still buffered
        push(2, 3);
        push(1, 1);
        t = 0;
        while (!(got_trig == 1 && !sif.trigger && steps >= 1) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("t5_reach_wait", int'(t < 400), 1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        got_trig = 0;
        @(posedge clk);
        @(negedge clk);
        check("t5_trigger", int'(sif.trigger), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ready", int'(cmd_ready), 1);
        check("t5_move_done", int'(move_done), 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (sif.trigger || move_done || busy) seen = 1;
        end
        check("t5_fifo_flushed", seen, 0);

`ifdef STEPPER_MASTER_TIMEOUT_EN
        // 6: watchdog on a slave whose done never returns
        @(negedge clk);
        to_valid = 1'b1; to_num = 8'sd3; to_width = 8'd1;
        @(posedge clk);
        #1 to_valid = 1'b0;
        t = 0;
        while (!sif_to.trigger && t < 50) begin @(negedge clk); t++; end
        while (sif_to.trigger && t < 100) begin @(negedge clk); t++; end
        check("t6_trigger_seen", int'(t < 50 + 50), 1);
        n = 0; seen = 0;
        for (int i = 0; i < 200 && !to_err; i++) begin
            @(posedge clk);
            if (clk_en) n++;
            #1;
            if (to_md) seen = 1;
        end
        check("t6_ticks_to_err", n, 16);
        check("t6_err", int'(to_err), 1);
        repeat (3) begin
            @(negedge clk);
            if (to_md) seen = 1;
        end
        check("t6_no_move_done", seen, 0);
        check("t6_idle", int'(to_busy), 0);
        check("t6_err_sticky", int'(to_err), 1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_err_reset", int'(to_err), 0);
        rst_n = 1'b1;
`endif

        // Random traffic plus the extreme counts
        md_base = md_count;
        push(-128, 1);
        push(127, 1);
        push(0, 0);
        for (int i = 0; i < 24; i++) begin
            cnum = int'($urandom_range(12)) - 6;
            cwid = int'($urandom_range(3));
            push(cnum, cwid);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        wait_idle("rand_idle");
        check("rand_md_count", md_count - md_base, 27);
        check("err_clear", int'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
